// File: rtl/seg7_scan_ctrl.sv
// Multiplexed N-digit seven-segment scanner with PWM brightness and double-buffered content.
// Optional leading-zero suppression when SEG7_LZ_SUPPRESS_EN is defined.
module seg7_scan_ctrl #(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned SCAN_DIV = 131072,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic                  upd_req,
  input  logic                  enable,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic                  busy,
  output logic                  frame_done,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            seg
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned SEL_W = $clog2(N_DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_DIGITS - 1);

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [4*N_DIGITS-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [N_DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [7:0]            seg_q, seg_d;
  logic                  slot_end, frame_end, digit_on;
  logic [3:0]            nib;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 7'h40;  4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;  4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;  4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;  4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;  4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;  4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;  4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;  default: hex_glyph = 7'h0E;
    endcase
  endfunction

  always_comb begin
    slot_end     = (div_cnt_q == DIV_LAST);
    frame_end    = slot_end && (sel_q == SEL_LAST);
    div_cnt_d    = slot_end ? '0 : div_cnt_q + 1'b1;
    sel_d        = sel_q;
    if (slot_end) sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    // A request landing on the wrap cycle goes straight to active and discards pending.
    if (upd_req && frame_end) begin
      act_data_d   = data;
      act_dp_d     = dp;
      act_blank_d  = blank;
      busy_d       = 1'b0;
      frame_done_d = 1'b1;
    end else if (upd_req) begin
      pend_data_d  = data;
      pend_dp_d    = dp;
      pend_blank_d = blank;
      busy_d       = 1'b1;
    end else if (frame_end && busy_q) begin
      act_data_d   = pend_data_q;
      act_dp_d     = pend_dp_q;
      act_blank_d  = pend_blank_q;
      busy_d       = 1'b0;
      frame_done_d = 1'b1;
    end
  end

`ifdef SEG7_LZ_SUPPRESS_EN
  logic [N_DIGITS-1:0] lz_mask;
  logic                lz_run;

  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      lz_run = lz_run && (act_data_q[4*(N_DIGITS-1-k) +: 4] == 4'h0);
      if (k != N_DIGITS - 1) lz_mask[N_DIGITS-1-k] = lz_run;
    end
  end
`endif

  always_comb begin
    nib      = act_data_q[{sel_q, 2'b00} +: 4];
    digit_on = enable && !act_blank_q[sel_q] &&
               (div_cnt_q[PWM_BITS-1:0] <= brightness);
    an_d     = '1;
    seg_d    = 8'hFF;
    if (digit_on) begin
      an_d[sel_q] = 1'b0;
      seg_d       = {~act_dp_q[sel_q], hex_glyph(nib)};
`ifdef SEG7_LZ_SUPPRESS_EN
      if (lz_mask[sel_q]) seg_d[6:0] = '1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      sel_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= 8'hFF;
    end else begin
      div_cnt_q    <= div_cnt_d;
      sel_q        <= sel_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign an         = an_q;
  assign seg        = seg_q;

endmodule
